// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the LEGv8 pipelined datapath.
package pipe_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // Instructions are word aligned; the two low address bits are dropped.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] adr);
        return {adr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with load/hold/flush; a flush inserts a NOP bubble, keeps pc.
// Latency: one clk edge from *_d to outputs.
// Backpressure: load=0 holds contents; flush beats load.
module if_id_reg
    import pipe_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [ADDR_W-1:0]  pc_d,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            pc    <= pc_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_fetch_stage.sv
// IF stage: PC register, imem address, IF/ID capture; halts when PC leaves imem.
// Latency: word at PC appears on if_id_* one edge after imem_adr=PC.
// Backpressure: stall holds PC and IF/ID; branch_taken overrides stall and flushes.
module pipe_fetch_stage
    import pipe_pkg::*;
#(
    parameter int unsigned        IMEM_SIZE = 256,
    parameter int unsigned        PC_STEP   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_adr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid,
    output logic               halted
);

    localparam logic [ADDR_W-1:0] IMEM_LIM = ADDR_W'(IMEM_SIZE);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic              load, flush;

    assign pc_inc   = pc_q + STEP;
    assign target   = align_word(branch_target);
    assign imem_adr = pc_q;
    assign halted   = (state_q == HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        if (branch_taken) begin
            pc_d    = target;
            flush   = 1'b1;
            state_d = (target >= IMEM_LIM) ? HALT : RUN;
        end else if (!stall) begin
            // The range guard also covers a RESET_PC placed outside imem.
            if (state_q == RUN && pc_q < IMEM_LIM) begin
                load    = 1'b1;
                pc_d    = pc_inc;
                state_d = (pc_inc >= IMEM_LIM) ? HALT : RUN;
            end else begin
                flush   = 1'b1;
                state_d = HALT;
            end
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .flush   (flush),
        .instr_d (imem_instr),
        .pc_d    (pc_q),
        .instr   (if_id_instr),
        .pc      (if_id_pc),
        .valid   (if_id_valid)
    );

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Bench for pipe_fetch_stage: directed scenarios plus random stall/redirect/reset traffic vs a reference model.
module tb_pipe_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken;
    logic [63:0] branch_target;
    logic [63:0] imem_adr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:255];

    // reference model state
    logic [63:0] m_pc;
    logic        m_halt;
    logic [31:0] m_instr;
    logic [63:0] m_ifpc;
    logic        m_valid;

    always #5 clk = ~clk;

    pipe_fetch_stage #(.IMEM_SIZE(256), .PC_STEP(4), .RESET_PC(64'd0)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_adr      (imem_adr),
        .imem_instr    (imem_instr),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    // Outside memory the word is nonzero junk, so any illegal capture shows up.
    function automatic logic [31:0] rd_word(input logic [63:0] a);
        if (a < 64'd253)
            return {mem[a[7:0] + 8'd3], mem[a[7:0] + 8'd2], mem[a[7:0] + 8'd1], mem[a[7:0]]};
        return 32'hBAD0_0000 ^ a[31:0] ^ 32'h1;
    endfunction

    always_comb imem_instr = rd_word(imem_adr);

    task automatic model_edge();
        logic [63:0] t;
        if (reset) begin
            m_pc = 64'd0; m_halt = 1'b0; m_instr = 32'd0; m_ifpc = 64'd0; m_valid = 1'b0;
        end else if (branch_taken) begin
            t = branch_target & ~64'd3;
            m_pc = t; m_instr = 32'd0; m_valid = 1'b0; m_halt = (t >= 64'd256);
        end else if (stall) begin
            // everything holds
        end else if (!m_halt) begin
            m_instr = rd_word(m_pc); m_ifpc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 64'd4;
            m_halt = (m_pc >= 64'd256);
        end else begin
            m_instr = 32'd0; m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem_adr !== 64'd0 || if_id_valid !== 1'b0 || halted !== 1'b0 ||
            if_id_instr !== 32'd0 || if_id_pc !== 64'd0) begin
            errors++;
            $display("FAIL reset: adr=%h valid=%b halted=%b instr=%h pc=%h required adr=0 valid=0 halted=0 instr=0 pc=0",
                     imem_adr, if_id_valid, halted, if_id_instr, if_id_pc);
        end
    endtask

    task automatic test_first_fetch();
        tick();
        checks++;
        if (if_id_instr !== 32'h8B1F03E5 || if_id_pc !== 64'd0 || if_id_valid !== 1'b1 || imem_adr !== 64'd4) begin
            errors++;
            $display("FAIL first_fetch: instr=%h pc=%h valid=%b adr=%h required 8b1f03e5/0/1/4",
                     if_id_instr, if_id_pc, if_id_valid, imem_adr);
        end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            tick();
            checks++;
            if (if_id_instr !== m_instr || if_id_pc !== m_ifpc || if_id_valid !== m_valid ||
                imem_adr !== m_pc || halted !== m_halt) begin
                errors++;
                $display("FAIL free_run cyc %0d: instr=%h pc=%h valid=%b adr=%h halted=%b required %h/%h/%b/%h/%b",
                         i, if_id_instr, if_id_pc, if_id_valid, imem_adr, halted,
                         m_instr, m_ifpc, m_valid, m_pc, m_halt);
            end
        end
        checks++;
        if (halted !== 1'b1 || if_id_pc !== 64'd252 || imem_adr !== 64'd256 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL free_run_end: halted=%b pc=%0d adr=%0d valid=%b required 1/252/256/1",
                     halted, if_id_pc, imem_adr, if_id_valid);
        end
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || imem_adr !== 64'd256 || halted !== 1'b1 || if_id_instr !== 32'd0) begin
            errors++;
            $display("FAIL halt_bubble: valid=%b adr=%0d halted=%b instr=%h required 0/256/1/0",
                     if_id_valid, imem_adr, halted, if_id_instr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w4;
        w4 = rd_word(64'd4);
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_adr !== 64'd8 || if_id_pc !== 64'd4 || if_id_instr !== w4 || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold %0d: adr=%h pc=%h instr=%h valid=%b required 8/4/%h/1",
                         i, imem_adr, if_id_pc, if_id_instr, if_id_valid, w4);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (if_id_pc !== 64'd8 || if_id_instr !== rd_word(64'd8) || imem_adr !== 64'd12) begin
            errors++;
            $display("FAIL stall_release: pc=%h instr=%h adr=%h required 8/%h/c",
                     if_id_pc, if_id_instr, imem_adr, rd_word(64'd8));
        end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h22;
        tick();
        checks++;
        if (imem_adr !== 64'h20 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc !== 64'd8) begin
            errors++;
            $display("FAIL redirect_stall: adr=%h valid=%b instr=%h pc=%h required 20/0/0/8",
                     imem_adr, if_id_valid, if_id_instr, if_id_pc);
        end
        idle_inputs();
        tick();
        checks++;
        if (if_id_instr !== 32'h8B040086 || if_id_pc !== 64'h20 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_capture: instr=%h pc=%h valid=%b required 8b040086/20/1",
                     if_id_instr, if_id_pc, if_id_valid);
        end
    endtask

    task automatic test_halt_redirect();
        int n = 0;
        while (halted !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_reach: halted=%b after %0d edges required 1", halted, n);
        end
        branch_taken = 1'b1; branch_target = 64'h10;
        tick();
        idle_inputs();
        checks++;
        if (halted !== 1'b0 || imem_adr !== 64'h10) begin
            errors++;
            $display("FAIL halt_redirect: halted=%b adr=%h required 0/10", halted, imem_adr);
        end
        tick();
        checks++;
        if (if_id_instr !== 32'hF84000A4 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL halt_redirect_fetch: instr=%h valid=%b required f84000a4/1", if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (imem_adr !== 64'd40) begin
            errors++;
            $display("FAIL stream_pc: adr=%0d required 40", imem_adr);
        end
        reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h80;
        tick();
        idle_inputs();
        checks++;
        if (imem_adr !== 64'd0 || if_id_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_override: adr=%h valid=%b halted=%b required 0/0/0", imem_adr, if_id_valid, halted);
        end
        branch_taken = 1'b1; branch_target = 64'h200;
        tick();
        idle_inputs();
        checks++;
        if (halted !== 1'b1 || if_id_valid !== 1'b0 || imem_adr !== 64'h200) begin
            errors++;
            $display("FAIL redirect_oob: halted=%b valid=%b adr=%h required 1/0/200", halted, if_id_valid, imem_adr);
        end
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || imem_adr !== 64'h200 || halted !== 1'b1) begin
            errors++;
            $display("FAIL oob_no_capture: valid=%b instr=%h adr=%h halted=%b required 0/0/200/1",
                     if_id_valid, if_id_instr, imem_adr, halted);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0)
                branch_target = {$urandom, $urandom};
            else
                branch_target = 64'($urandom_range(0, 300));
            tick();
            checks++;
            if (if_id_instr !== m_instr || if_id_pc !== m_ifpc || if_id_valid !== m_valid ||
                imem_adr !== m_pc || halted !== m_halt) begin
                errors++;
                $display("FAIL random cyc %0d: instr=%h pc=%h valid=%b adr=%h halted=%b required %h/%h/%b/%h/%b",
                         i, if_id_instr, if_id_pc, if_id_valid, imem_adr, halted,
                         m_instr, m_ifpc, m_valid, m_pc, m_halt);
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        {mem[3], mem[2], mem[1], mem[0]}     = 32'h8B1F03E5;
        {mem[19], mem[18], mem[17], mem[16]} = 32'hF84000A4;
        {mem[35], mem[34], mem[33], mem[32]} = 32'h8B040086;
        idle_inputs();
        m_pc = 64'd0; m_halt = 1'b0; m_instr = 32'd0; m_ifpc = 64'd0; m_valid = 1'b0;

        test_reset();
        test_first_fetch();
        test_free_run();
        test_stall();
        test_redirect_over_stall();
        test_halt_redirect();
        test_reset_mid_stream();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
